// File: rtl/branch_target_buffer.sv
// Fetch-stage branch target buffer: direct-mapped, zero-latency lookup,
// trained by EX-stage branch feedback, with a clear sweep after reset/flush.
//
// Optional build macro: BTB_BYPASS_EN
//   defined   - a same-cycle update to the looked-up index is forwarded into
//               the lookup result (post-update entry is seen).
//   undefined - lookup sees the stored (pre-update) entry.
//
// Handshake: there is no backpressure on either port. A lookup is answered in
// the same cycle it is presented; an update is consumed on the posedge only
// when i_update_valid and o_ready are both 1 and i_flush is 0, otherwise it is
// dropped. o_ready is 0 for the whole clear sweep.
//
// Controller state (FSM state + sweep index) lives in the packed struct ctl_q,
// which is the debug view of the FSM.
module branch_target_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic [ADDR_WIDTH-1:0] o_target,
  output logic                  o_ready,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  input  logic                  i_update_taken,
  input  logic                  i_flush
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Controller state: FSM state plus sweep index. The index MSB is the
  // terminal flag that ends the sweep.
  typedef struct packed {
    state_t                state;
    logic [INDEX_BITS:0]   clr_idx;
  } ctl_t;

  ctl_t ctl_q;
  ctl_t ctl_d;

  // Table storage. valid/ctr are cleared by the sweep; tag/target are never
  // reset so they can map onto plain RAM.
  logic [ENTRIES-1:0]    valid_q;
  logic [1:0]            ctr_mem [ENTRIES];
  logic [TAG_BITS-1:0]   tag_mem [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_mem [ENTRIES];

  // Address fields.
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic [INDEX_BITS-1:0] clr_addr;
  logic [INDEX_BITS:0]   clr_idx_inc;

  // pc[1:0] carry no information for instruction addresses.
  logic unused_pc_lsbs;

  // Update-side decode.
  logic       up_hit;
  logic       up_commit;
  logic       up_meta_we;
  logic       up_data_we;
  logic [1:0] up_ctr_old;
  logic [1:0] up_ctr_new;

  // Lookup-side view of the selected entry (possibly forwarded).
  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_tag_s;
  logic [ADDR_WIDTH-1:0] lk_tgt;
  logic [1:0]            lk_ctr;

  assign lk_idx   = i_lookup_pc[INDEX_BITS+1:2];
  assign lk_tag   = i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx   = i_update_pc[INDEX_BITS+1:2];
  assign up_tag   = i_update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign clr_addr = ctl_q.clr_idx[INDEX_BITS-1:0];
  assign clr_idx_inc = ctl_q.clr_idx + 1'b1;

  assign unused_pc_lsbs = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

  assign o_ready = (ctl_q.state == ST_RUN);

  // Controller register: synchronous active-low reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q <= '{state: ST_CLEAR, clr_idx: '0};
    end else begin
      ctl_q <= ctl_d;
    end
  end

  // Controller next state: walk every index once, then run; flush restarts.
  always_comb begin
    ctl_d = ctl_q;
    case (ctl_q.state)
      ST_CLEAR: begin
        if (i_flush) begin
          ctl_d.clr_idx = '0;
        end else if (clr_idx_inc[INDEX_BITS]) begin
          ctl_d.state   = ST_RUN;
          ctl_d.clr_idx = '0;
        end else begin
          ctl_d.clr_idx = clr_idx_inc;
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          ctl_d.state   = ST_CLEAR;
          ctl_d.clr_idx = '0;
        end
      end
      default: begin
        ctl_d.state   = ST_CLEAR;
        ctl_d.clr_idx = '0;
      end
    endcase
  end

  // Update decode: an update commits only in RUN, outside reset and flush.
  // A taken branch always writes (install or refresh); a not-taken branch
  // only touches an entry that already holds this branch.
  assign up_hit     = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_commit  = rst_n && i_update_valid && o_ready && !i_flush;
  assign up_meta_we = up_commit && (i_update_taken || up_hit);
  assign up_data_we = up_commit && i_update_taken;
  assign up_ctr_old = ctr_mem[up_idx];

  // Hysteresis counter next value: saturating, installs start weakly taken.
  always_comb begin
    up_ctr_new = up_ctr_old;
    if (i_update_taken) begin
      if (!up_hit) begin
        up_ctr_new = 2'b10;
      end else if (up_ctr_old != 2'b11) begin
        up_ctr_new = up_ctr_old + 2'd1;
      end
    end else if (up_hit && (up_ctr_old != 2'b00)) begin
      up_ctr_new = up_ctr_old - 2'd1;
    end
  end

  // valid/ctr write port: the sweep owns the table while clearing,
  // otherwise a committed update writes its entry.
  always_ff @(posedge clk) begin
    if (ctl_q.state == ST_CLEAR) begin
      valid_q[clr_addr] <= 1'b0;
      ctr_mem[clr_addr] <= 2'b00;
    end else if (up_meta_we) begin
      valid_q[up_idx] <= 1'b1;
      ctr_mem[up_idx] <= up_ctr_new;
    end
  end

  // tag/target write port: only taken branches carry a target worth storing.
  always_ff @(posedge clk) begin
    if (up_data_we) begin
      tag_mem[up_idx] <= up_tag;
      tgt_mem[up_idx] <= i_update_target;
    end
  end

  // Lookup read, optionally forwarding a same-cycle update to the same index.
  always_comb begin
    lk_valid = valid_q[lk_idx];
    lk_tag_s = tag_mem[lk_idx];
    lk_tgt   = tgt_mem[lk_idx];
    lk_ctr   = ctr_mem[lk_idx];
`ifdef BTB_BYPASS_EN
    if (up_meta_we && (up_idx == lk_idx)) begin
      lk_valid = 1'b1;
      lk_tag_s = up_tag;
      lk_ctr   = up_ctr_new;
      if (i_update_taken) begin
        lk_tgt = i_update_target;
      end
    end
`endif
  end

  // Prediction outputs: taken only for a matching entry in the upper half
  // of the counter range; target is zero unless the entry is usable.
  assign o_hit    = i_lookup_valid && o_ready && lk_valid &&
                    (lk_tag_s == lk_tag) && (lk_ctr >= 2'b10);
  assign o_target = (o_ready && lk_valid) ? lk_tgt : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with
// literal expectations plus a randomized phase, all checked every cycle
// against an entry-array reference model. Honours BTB_BYPASS_EN.
module tb_branch_target_buffer;

  localparam int AW = 32;
  localparam int IB = 6;
  localparam int NE = 1 << IB;
  localparam int TB = AW - IB - 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_lookup_valid = 1'b0;
  logic [AW-1:0] i_lookup_pc = '0;
  logic          o_hit;
  logic [AW-1:0] o_target;
  logic          o_ready;
  logic          i_update_valid = 1'b0;
  logic [AW-1:0] i_update_pc = '0;
  logic [AW-1:0] i_update_target = '0;
  logic          i_update_taken = 1'b0;
  logic          i_flush = 1'b0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_lookup_valid  (i_lookup_valid),
    .i_lookup_pc     (i_lookup_pc),
    .o_hit           (o_hit),
    .o_target        (o_target),
    .o_ready         (o_ready),
    .i_update_valid  (i_update_valid),
    .i_update_pc     (i_update_pc),
    .i_update_target (i_update_target),
    .i_update_taken  (i_update_taken),
    .i_flush         (i_flush)
  );

`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            valid;
    logic [TB-1:0] tag;
    logic [AW-1:0] tgt;
    int            ctr;
  } ent_t;

  ent_t model[NE];
  int   busy = NE;  // cycles of clearing still to go; 0 means table usable

  function automatic ent_t apply_upd(ent_t e, logic [TB-1:0] tg, logic [AW-1:0] t, bit taken);
    ent_t r;
    bit   match;
    r = e;
    match = e.valid && (e.tag == tg);
    if (taken && match) begin
      r.tgt = t;
      r.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
    end else if (taken) begin
      r.valid = 1'b1;
      r.tag   = tg;
      r.tgt   = t;
      r.ctr   = 2;
    end else if (match) begin
      r.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
    end
    return r;
  endfunction

  // ---------------- scoreboard: compare every cycle, then advance model ----
  ent_t cmp_e;
  bit   cmp_rdy;
  bit   cmp_hit;
  int   cmp_li;
  int   cmp_ui;

  initial begin
    for (int i = 0; i < NE; i++) begin
      model[i].valid = 1'b0;
      model[i].tag   = '0;
      model[i].tgt   = '0;
      model[i].ctr   = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      cmp_rdy = (busy == 0);
      cmp_li  = int'(i_lookup_pc[IB+1:2]);
      cmp_ui  = int'(i_update_pc[IB+1:2]);
      cmp_e   = model[cmp_li];
      if (BYP && rst_n && cmp_rdy && i_update_valid && !i_flush && (cmp_ui == cmp_li))
        cmp_e = apply_upd(model[cmp_ui], i_update_pc[AW-1:IB+2], i_update_target, i_update_taken);
      cmp_hit = i_lookup_valid && cmp_rdy && cmp_e.valid &&
                (cmp_e.tag == i_lookup_pc[AW-1:IB+2]) && (cmp_e.ctr >= 2);
      check("ready", 32'(o_ready), 32'(cmp_rdy));
      check("hit", 32'(o_hit), 32'(cmp_hit));
      if (cmp_hit) check("target", o_target, cmp_e.tgt);
      @(posedge clk);
      if (!rst_n || i_flush) begin
        for (int i = 0; i < NE; i++) model[i].valid = 1'b0;
        busy = NE;
      end else if (busy > 0) begin
        busy--;
      end else if (i_update_valid) begin
        model[cmp_ui] = apply_upd(model[cmp_ui], i_update_pc[AW-1:IB+2],
                                  i_update_target, i_update_taken);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs just after the negedge; returns once the
  // combinational outputs for those inputs have settled.
  task automatic drive(input bit rs, input bit lv, input logic [AW-1:0] lpc,
                       input bit uv, input logic [AW-1:0] upc,
                       input logic [AW-1:0] ut, input bit tk, input bit fl);
    @(negedge clk);
    #1;
    rst_n           = !rs;
    i_lookup_valid  = lv;
    i_lookup_pc     = lpc;
    i_update_valid  = uv;
    i_update_pc     = upc;
    i_update_target = ut;
    i_update_taken  = tk;
    i_flush         = fl;
    #1;
  endtask

  function automatic logic [AW-1:0] rand_pc();
    logic [TB-1:0] tg;
    logic [IB-1:0] ix;
    logic [1:0]    lo;
    tg = 24'h004000 + 24'($urandom_range(0, 2));
    ix = 6'($urandom_range(4, 7));
    lo = 2'($urandom_range(0, 3));
    return {tg, ix, lo};
  endfunction

  task automatic look(input logic [AW-1:0] pc);
    drive(1'b0, 1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic [AW-1:0] t, input bit tk);
    drive(1'b0, 1'b0, '0, 1'b1, pc, t, tk, 1'b0);
  endtask

  // Counts consecutive cycles with o_ready=0, starting with the next driven
  // cycle (which also releases reset). Bounded so a stuck sweep still ends.
  task automatic count_busy(output int n);
    n = 0;
    drive(1'b0, 1'b1, rand_pc(), 1'b1, rand_pc(), $urandom, 1'b1, 1'b0);
    while (!o_ready && n < 200) begin
      n++;
      check("sweep_hit", 32'(o_hit), 32'd0);
      drive(1'b0, 1'b1, rand_pc(), 1'b1, rand_pc(), $urandom, 1'b1, 1'b0);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  int n;

  initial begin
    // reset, with lookups and updates that must be ignored
    repeat (3) drive(1'b1, 1'b1, rand_pc(), 1'b1, rand_pc(), $urandom, 1'b1, 1'b0);
    check("reset_ready", 32'(o_ready), 32'd0);
    check("reset_hit", 32'(o_hit), 32'd0);
    check("reset_target", o_target, 32'd0);
    count_busy(n);
    check("reset_sweep_len", 32'(n), 32'd64);

    // install, hit, same index / different tag misses
    upd(32'h0040_0010, 32'h0040_0100, 1'b1);
    look(32'h0040_0010);
    check("install_hit", 32'(o_hit), 32'd1);
    check("install_target", o_target, 32'h0040_0100);
    look(32'h0080_0010);
    check("alias_tag_miss", 32'(o_hit), 32'd0);

    // hysteresis
    upd(32'h0040_0010, 32'h0040_0100, 1'b0);
    look(32'h0040_0010);
    check("hyst_ctr01", 32'(o_hit), 32'd0);
    upd(32'h0040_0010, 32'h0040_0100, 1'b1);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1);
    look(32'h0040_0010);
    check("hyst_ctr11", 32'(o_hit), 32'd1);
    check("hyst_retarget", o_target, 32'h0040_0200);
    upd(32'h0040_0010, 32'h0040_0200, 1'b0);
    look(32'h0040_0010);
    check("hyst_ctr10", 32'(o_hit), 32'd1);
    repeat (3) upd(32'h0040_0010, 32'h0040_0200, 1'b0);
    look(32'h0040_0010);
    check("hyst_ctr00", 32'(o_hit), 32'd0);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1);
    look(32'h0040_0010);
    check("hyst_floor", 32'(o_hit), 32'd0);

    // not-taken on an empty entry allocates nothing
    upd(32'h0040_0020, 32'h0000_1234, 1'b0);
    look(32'h0040_0020);
    check("nt_miss_noalloc", 32'(o_hit), 32'd0);

    // populate three entries, then flush with a simultaneous taken update
    upd(32'h0040_0010, 32'h0040_0300, 1'b1);
    upd(32'h0040_0030, 32'h0040_0400, 1'b1);
    upd(32'h0040_0044, 32'h0040_0500, 1'b1);
    look(32'h0040_0010);
    check("pop_hit_a", 32'(o_hit), 32'd1);
    look(32'h0040_0030);
    check("pop_hit_b", 32'(o_hit), 32'd1);
    check("pop_target_b", o_target, 32'h0040_0400);
    look(32'h0040_0044);
    check("pop_hit_c", 32'(o_hit), 32'd1);
    drive(1'b0, 1'b1, 32'h0040_0044, 1'b1, 32'h0040_0058, 32'h0040_0600, 1'b1, 1'b1);
    count_busy(n);
    check("flush_sweep_len", 32'(n), 32'd64);
    look(32'h0040_0010);
    check("flushed_a", 32'(o_hit), 32'd0);
    look(32'h0040_0030);
    check("flushed_b", 32'(o_hit), 32'd0);
    look(32'h0040_0044);
    check("flushed_c", 32'(o_hit), 32'd0);
    look(32'h0040_0058);
    check("flush_dropped_upd", 32'(o_hit), 32'd0);

    // re-flush mid-sweep restarts the full count
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    repeat (30) look(rand_pc());
    check("mid_sweep_ready", 32'(o_ready), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    count_busy(n);
    check("reflush_sweep_len", 32'(n), 32'd64);

    // same-cycle lookup and install of the same PC
    drive(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    check("conflict_hit", 32'(o_hit), 32'(BYP));
    look(32'h0040_0010);
    check("conflict_next_hit", 32'(o_hit), 32'd1);
    check("conflict_next_target", o_target, 32'h0040_0100);

    // randomized traffic over a small colliding PC pool
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 599) == 0,
            1'($urandom),
            rand_pc(),
            $urandom_range(0, 2) != 0,
            rand_pc(),
            32'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 149) == 0);
    end
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
